// File: rtl/calc_pkg.sv
// calc_pkg: scanner state encoding, key code width and calculator key codes.
package calc_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  localparam int KEY_W = 4;
  localparam logic [KEY_W-1:0] KEY_0 = 4'd0;
  localparam logic [KEY_W-1:0] KEY_1 = 4'd1;
  localparam logic [KEY_W-1:0] KEY_2 = 4'd2;
  localparam logic [KEY_W-1:0] KEY_3 = 4'd3;
  localparam logic [KEY_W-1:0] KEY_4 = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5 = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6 = 4'd6;
  localparam logic [KEY_W-1:0] KEY_7 = 4'd7;
  localparam logic [KEY_W-1:0] KEY_8 = 4'd8;
  localparam logic [KEY_W-1:0] KEY_9 = 4'd9;
  localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
  localparam logic [KEY_W-1:0] KEY_DIV = 4'd13;
  localparam logic [KEY_W-1:0] KEY_EQ = 4'd14;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'd15;
  // index of the lowest zero bit; serves both row_n decode and column priority
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, synchronous active-low reset.
module sync2 #(
  parameter int W = 1,
  parameter logic [W-1:0] INIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk)
    if (!rst_n) {q, m} <= {INIT, INIT};
    else {q, m} <= {m, d};
endmodule

// File: rtl/keypad_scan_rx.sv
// keypad_scan_rx: 4x4 active-low keypad scanner/debouncer emitting one key_valid per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scan_rx
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int CNT_W = 10
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE = 100
`endif
) (
  input  logic             clk_12MHz,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [3:0]       col_n,
  output logic [3:0]       row_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);
  logic [3:0] col_s, row_adv;
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [KEY_W-1:0] cand, code;
  logic hit, cand_hit, db_done;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep;
  logic rep_on;
`endif
  sync2 #(.W(4)) u_sync (.clk(clk_12MHz), .rst_n(rst_n), .d(col_n), .q(col_s));
  always_comb begin
    hit = ~&col_s;
    code = {low_idx(row_n), low_idx(col_s)};
    cand_hit = ~col_s[cand[1:0]];
    cnt_inc = cnt + 1'b1;
    db_done = cnt_inc == CNT_W'(DEBOUNCE_TICKS);
    row_adv = {row_n[2:0], row_n[3]};
  end
  always_ff @(posedge clk_12MHz) begin
    if (!rst_n) begin
      state <= SCAN;
      cnt <= '0;
      cand <= '0;
      row_n <= 4'b1110;
      key_code <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep <= '0;
      rep_on <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick)
        case (state)
          // SCAN always holds cnt=0, so db_done here means a one-tick debounce
          SCAN, DEBOUNCE:
            if (hit && (state == SCAN || code == cand)) begin
              cand <= code;
              if (db_done) begin
                key_code <= code;
                key_valid <= 1'b1;
                key_held <= 1'b1;
                cnt <= '0;
                state <= PRESSED;
              end else begin
                cnt <= cnt_inc;
                state <= DEBOUNCE;
              end
            end else begin
              cnt <= '0;
              state <= SCAN;
              row_n <= row_adv;
            end
          PRESSED:
            if (cand_hit) begin
              cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rep + 1'b1 == CNT_W'(rep_on ? REPEAT_RATE : REPEAT_DELAY)) begin
                key_valid <= 1'b1;
                rep <= '0;
                rep_on <= 1'b1;
              end else rep <= rep + 1'b1;
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rep <= '0;
              rep_on <= 1'b0;
`endif
              if (db_done) begin
                key_held <= 1'b0;
                cnt <= '0;
                state <= SCAN;
              end else cnt <= cnt_inc;
            end
          default: state <= SCAN;
        endcase
    end
  end
endmodule
